// File: rtl/ff_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter: requests, data slices,
// one-hot grant and the shared register view.
interface ff_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [IDXW-1:0]       owner;
  logic                  busy;

  modport master (
    output req, wdata,
    input  gnt, q, q_valid, owner, busy
  );

  modport slave (
    input  req, wdata,
    output gnt, q, q_valid, owner, busy
  );
endinterface

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter that is the sole writer of a shared WIDTH-bit register.
// Optional macro ARB_B2B_EN: chain grants back-to-back without an IDLE cycle.
module ff_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ff_write_arbiter_if.slave   bus
);
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [IDXW-1:0]   win_q, win_d;

  logic [IDXW:0]     pick_idle;
  logic [WIDTH-1:0]  win_data;

  // Returns {found, index}: first requester after 'l' in round-robin order.
  // Scanning from the far end lets the nearest match overwrite earlier ones.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] l);
    logic [IDXW:0] res;
    int            j;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(l) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[j[IDXW-1:0]]) res = {1'b1, j[IDXW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign pick_idle = rr_pick(bus.req, last_q);
  assign win_data  = bus.wdata[int'(win_q)*WIDTH +: WIDTH];

`ifdef ARB_B2B_EN
  logic [IDXW:0] pick_b2b;
  assign pick_b2b = rr_pick(bus.req, last_d);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    last_d    = last_q;
    win_d     = win_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[IDXW]) begin
          win_d   = pick_idle[IDXW-1:0];
          gnt_d   = onehot(pick_idle[IDXW-1:0]);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request aborts: register, owner and pointer stay put.
        if (bus.req[win_q]) begin
          q_d       = win_data;
          q_valid_d = 1'b1;
          owner_d   = win_q;
          last_d    = win_q;
        end
        state_d = IDLE;
`ifdef ARB_B2B_EN
        if (pick_b2b[IDXW]) begin
          win_d   = pick_b2b[IDXW-1:0];
          gnt_d   = onehot(pick_b2b[IDXW-1:0]);
          state_d = GRANT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      last_q    <= IDXW'(NREQ - 1);
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      win_q     <= win_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == GRANT);

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Bench for ff_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_ff_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  ff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an outstanding grant (if any), the rr pointer and the register view.
  bit         m_busy  = 1'b0;
  int         m_w     = 0;
  int         m_last  = NREQ - 1;
  logic [3:0] m_gnt   = '0;
  logic [7:0] m_q     = '0;
  bit         m_qv    = 1'b0;
  int         m_owner = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_grant(input logic [3:0] r);
    bit found;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (!found && r[i]) begin
        found = 1'b1;
        m_w   = i;
      end
    end
    m_busy = 1'b1;
    m_gnt  = 4'(1 << m_w);
  endtask

  task automatic model_step();
    logic [3:0]  r;
    logic [31:0] wd;
    r  = bus.req;
    wd = bus.wdata;
    if (rst) begin
      m_busy = 0; m_gnt = 0; m_q = 0; m_qv = 0; m_owner = 0; m_last = NREQ - 1; m_w = 0;
    end else if (m_busy) begin
      if (r[m_w]) begin
        m_q     = wd[m_w*8 +: 8];
        m_qv    = 1'b1;
        m_owner = m_w;
        m_last  = m_w;
      end
      m_busy = 1'b0;
      m_gnt  = '0;
`ifdef ARB_B2B_EN
      if (|r) model_grant(r);
`endif
    end else if (|r) begin
      model_grant(r);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("cyc_gnt",   32'(bus.gnt),     32'(m_gnt));
    chk("cyc_q",     32'(bus.q),       32'(m_q));
    chk("cyc_qv",    32'(bus.q_valid), 32'(m_qv));
    chk("cyc_owner", 32'(bus.owner),   32'(m_owner[1:0]));
    chk("cyc_busy",  32'(bus.busy),    32'(m_busy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slices(input logic [7:0] s0, s1, s2, s3);
    bus.wdata = {s3, s2, s1, s0};
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 4'hF;
    set_slices(8'h11, 8'h22, 8'h33, 8'h44);

    // T1: reset held with all requests active
    for (int n = 0; n < 2; n++) begin
      step();
      chk("t1_gnt", 32'(bus.gnt), 0);
      chk("t1_q", 32'(bus.q), 0);
      chk("t1_qv", 32'(bus.q_valid), 0);
      chk("t1_owner", 32'(bus.owner), 0);
      chk("t1_busy", 32'(bus.busy), 0);
    end
    rst = 1'b0; bus.req = '0;
    step();

    // T2: single requester
    bus.req = 4'b0010;
    set_slices(8'h00, 8'hA5, 8'h00, 8'h00);
    step();
    chk("t2_gnt", 32'(bus.gnt), 32'h2);
    chk("t2_busy", 32'(bus.busy), 1);
    step();
    bus.req = '0;
    chk("t2_q", 32'(bus.q), 32'hA5);
    chk("t2_qv", 32'(bus.q_valid), 1);
    chk("t2_owner", 32'(bus.owner), 1);
    step(); step();

    // T3: fairness under constant all-ones requests
    do_reset();
    set_slices(8'h10, 8'h11, 8'h12, 8'h13);
    bus.req = 4'hF;
`ifdef ARB_B2B_EN
    step();
    chk("t3_gnt0", 32'(bus.gnt), 32'h1);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_q", 32'(bus.q), 32'(8'h10 + n % 4));
      chk("t3_gnt", 32'(bus.gnt), 32'(1 << ((n + 1) % 4)));
    end
`else
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_gnt", 32'(bus.gnt), 32'(1 << (n % 4)));
      step();
      chk("t3_q", 32'(bus.q), 32'(8'h10 + n % 4));
      chk("t3_gap", 32'(bus.gnt), 0);
    end
`endif
    bus.req = '0;
    step(); step();

    // T4: abort, then pointer still at 3 so requester 0 wins
    do_reset();
    set_slices(8'h01, 8'h02, 8'h77, 8'h04);
    bus.req = 4'b0100;
    step();
    chk("t4_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step();
    chk("t4_q", 32'(bus.q), 0);
    chk("t4_qv", 32'(bus.q_valid), 0);
    chk("t4_owner", 32'(bus.owner), 0);
    bus.req = 4'b0101;
    step();
    chk("t4_regnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step(); step();

    // T5: reset during GRANT suppresses the write
    set_slices(8'h00, 8'h00, 8'h00, 8'h3C);
    bus.req = 4'b1000;
    step();
    chk("t5_gnt", 32'(bus.gnt), 32'h8);
    rst = 1'b1;
    step();
    chk("t5_gnt_rst", 32'(bus.gnt), 0);
    chk("t5_q_rst", 32'(bus.q), 0);
    chk("t5_qv_rst", 32'(bus.q_valid), 0);
    rst = 1'b0; bus.req = '0;
    step();
    chk("t5_q_after", 32'(bus.q), 0);

    // T6: late arrival during GRANT is served next
    do_reset();
    set_slices(8'h5A, 8'h6B, 8'h00, 8'h00);
    bus.req = 4'b0001;
    step();
    chk("t6_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0011;
    step();
    chk("t6_q", 32'(bus.q), 32'h5A);
    chk("t6_owner", 32'(bus.owner), 0);
    bus.req = 4'b0010;
`ifdef ARB_B2B_EN
    chk("t6_gnt1", 32'(bus.gnt), 32'h2);
`else
    chk("t6_idle", 32'(bus.gnt), 0);
    step();
    chk("t6_gnt1", 32'(bus.gnt), 32'h2);
`endif
    step();
    chk("t6_q1", 32'(bus.q), 32'h6B);
    bus.req = '0;
    step(); step();

    // Randomized traffic: requesters usually hold while granted, sometimes abort.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (m_busy && $urandom_range(0, 9) != 0) r[m_w] = 1'b1;
      bus.req   = r;
      bus.wdata = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; bus.req = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
